scan_chain_driver: RTL and testbench
====================================

// Module: scan_chain_driver
// PURPOSE
//  Tester-side end of the serial scan interface: drives se/si into a scan chain and captures so.
//  Accepts one pattern (load data + expected unload) per valid/ready transfer.
//  Shifts the pattern in over CHAIN_LEN clocks while unloading the previous chain contents.
//  Compares the unload with the expected data, returns a result, and keeps saturating pass/fail tallies.
// PARAMETERS
//  CHAIN_LEN   8   scan chain length in flops (>=2); width of all pattern/response buses
//  TALLY_W     16  width of the pass_cnt/fail_cnt tally counters
// PORTS
//  sclk        in   1          scan clock; all logic on posedge
//  rst_n       in   1          asynchronous active-low reset
//  pat_valid   in   1          pattern offered
//  pat_ready   out  1          driver can accept a pattern
//  pat_load    in   CHAIN_LEN  value the chain must hold after the shift
//  pat_exp     in   CHAIN_LEN  expected unload (chain contents before the shift)
//  pat_mask    in   CHAIN_LEN  1 = compare this bit (SCAN_XMASK_EN only; ignored otherwise)
//  se          out  1          scan enable to the chain
//  si          out  1          scan in to the chain
//  so          in   1          scan out from the chain (chain MSB)
//  res_valid   out  1          result available
//  res_ready   in   1          result consumed
//  res_data    out  CHAIN_LEN  captured unload
//  res_fail    out  1          1 = at least one compared bit mismatched
//  res_errs    out  $clog2(CHAIN_LEN+1)  number of mismatching compared bits
//  pass_cnt    out  TALLY_W    passed patterns, saturating
//  fail_cnt    out  TALLY_W    failed patterns, saturating
// BEHAVIOUR
//  - Reset: IDLE; se=0, si=0, pat_ready=1, res_valid=0, res_data=0, res_fail=0, res_errs=0, counters=0.
//  - se and si are registered outputs. The chain shifts toward its MSB, and so is the chain MSB.
//  - IDLE: pat_ready=1. Transfer occurs on pat_valid&&pat_ready at a posedge.
//    - On that edge: latch load/exp/mask, set k=0, go to SHIFT, se<=1, si<=pat_load[CHAIN_LEN-1].
//  - SHIFT, k=0..CHAIN_LEN-1: pat_ready=0, se=1, si=load[CHAIN_LEN-1-k].
//    - At the end-of-cycle posedge, the chain shifts and the driver samples so into res_data[CHAIN_LEN-1-k].
//    - si<=load[CHAIN_LEN-2-k] and k<=k+1.
//  - After the sample with k=CHAIN_LEN-1: se<=0, si<=0, go to RESULT.
//    - res_valid<=1; res_errs/res_fail are valid in the same cycle.
//    - The tally update (pass_cnt or fail_cnt +1, hold at all-ones) occurs on this same edge.
//  - Latency: res_valid rises exactly CHAIN_LEN cycles after the accept edge; se is high for exactly CHAIN_LEN cycles.
//  - RESULT: res_* held stable while res_valid && !res_ready; pat_ready=0.
//    - On res_valid&&res_ready: res_valid<=0, go to IDLE.
//    - Earliest next accept is the cycle after the result handshake (no overlap; one pattern in flight).
//  - res_errs = popcount((res_data ^ exp) & cmp_mask); res_fail = (res_errs != 0).
//  - pat_valid in SHIFT/RESULT is ignored (not accepted); pat_* only sampled at accept.
//  - so is sampled only in SHIFT; so toggling in IDLE/RESULT has no effect.
//  - rst_n assertion mid-SHIFT: immediate return to reset state with se=0.
//    - The partial pattern is discarded and no tally update occurs; chain contents are undefined thereafter.
// CONFIGURATION
//  SCAN_XMASK_EN defined:   cmp_mask = latched pat_mask; masked bits are still captured in res_data but never counted.
//  SCAN_XMASK_EN undefined: cmp_mask = all ones; pat_mask port present but unused.
// TESTING (bench: driver wired to an 8-flop scan chain, se/si/so direct, CHAIN_LEN=8)
//  1. Reset, then load=8'hA5, exp=8'h00 (chain pre-cleared by flush 8'h00)
//     -> se high 8 cycles; res_data=8'h00, res_fail=0, pass_cnt=1.
//  2. Follow with load=8'h3C, exp=8'hA5 -> res_data=8'hA5, res_errs=0; then load=8'h00, exp=8'hFF
//     -> res_data=8'h3C, res_errs=4, res_fail=1, fail_cnt=1.
//  3. Hold res_ready=0 for 5 cycles with pat_valid=1 -> res_* stable, pat_ready=0, se=0, no second accept.
//  4. Assert rst_n=0 at k=3 of SHIFT -> se=0 and res_valid=0 immediately; counters=0; next pattern accepted normally.
//  5. SCAN_XMASK_EN: exp=8'hFF, mask=8'h0F, unload 8'h0F -> res_errs=0, res_fail=0; without macro -> res_errs=4.
//  6. Stuck-at-1 on the chain's so -> load 8'h00 twice -> second result res_data=8'hFF, res_errs=8.

Source files
------------

// File: rtl/scan_chain_driver.sv
// Tester-side scan driver: shifts one pattern into the chain while unloading and grading the old contents.
// Optional per-bit compare masking is enabled by defining SCAN_XMASK_EN.
module scan_chain_driver #(
  parameter int CHAIN_LEN = 8,
  parameter int TALLY_W   = 16
) (
  input  logic                           sclk,
  input  logic                           rst_n,
  input  logic                           pat_valid,
  output logic                           pat_ready,
  input  logic [CHAIN_LEN-1:0]           pat_load,
  input  logic [CHAIN_LEN-1:0]           pat_exp,
  input  logic [CHAIN_LEN-1:0]           pat_mask,
  output logic                           se,
  output logic                           si,
  input  logic                           so,
  output logic                           res_valid,
  input  logic                           res_ready,
  output logic [CHAIN_LEN-1:0]           res_data,
  output logic                           res_fail,
  output logic [$clog2(CHAIN_LEN+1)-1:0] res_errs,
  output logic [TALLY_W-1:0]             pass_cnt,
  output logic [TALLY_W-1:0]             fail_cnt
);

  localparam int ERRS_W = $clog2(CHAIN_LEN + 1);
  localparam int K_W    = $clog2(CHAIN_LEN);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_RESULT
  } state_t;

  state_t                state_q, state_d;
  logic [K_W-1:0]        k_q;
  logic [CHAIN_LEN-1:0]  load_sr;
  logic [CHAIN_LEN-1:0]  exp_q;
  logic [CHAIN_LEN-1:0]  cmp_mask;
  logic [CHAIN_LEN-1:0]  capture;
  logic [ERRS_W-1:0]     errs_d;
  logic                  accept;
  logic                  last_shift;

  function automatic logic [ERRS_W-1:0] popcount(input logic [CHAIN_LEN-1:0] v);
    logic [ERRS_W-1:0] c;
    c = '0;
    for (int i = 0; i < CHAIN_LEN; i++) c = c + ERRS_W'(v[i]);
    return c;
  endfunction

`ifdef SCAN_XMASK_EN
  logic [CHAIN_LEN-1:0] mask_q;

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n)      mask_q <= '0;
    else if (accept) mask_q <= pat_mask;
  end

  assign cmp_mask = mask_q;
`else
  logic unused_mask;

  assign unused_mask = ^pat_mask;
  assign cmp_mask    = '1;
`endif

  // The unloaded bit enters at the LSB, so after CHAIN_LEN samples the first one sits at the MSB.
  assign capture    = {res_data[CHAIN_LEN-2:0], so};
  assign errs_d     = popcount((capture ^ exp_q) & cmp_mask);
  assign accept     = pat_valid && pat_ready;
  assign last_shift = (state_q == S_SHIFT) && (k_q == K_W'(CHAIN_LEN - 1));

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    pat_ready = 1'b0;
    case (state_q)
      S_IDLE: begin
        pat_ready = 1'b1;
        if (pat_valid) state_d = S_SHIFT;
      end
      S_SHIFT: begin
        if (last_shift) state_d = S_RESULT;
      end
      S_RESULT: begin
        if (res_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      k_q       <= '0;
      load_sr   <= '0;
      exp_q     <= '0;
      se        <= 1'b0;
      si        <= 1'b0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_errs  <= '0;
      res_fail  <= 1'b0;
      pass_cnt  <= '0;
      fail_cnt  <= '0;
    end else if (accept) begin
      // si presents the MSB now; the remaining bits queue up behind it in load_sr.
      load_sr <= pat_load << 1;
      exp_q   <= pat_exp;
      k_q     <= '0;
      se      <= 1'b1;
      si      <= pat_load[CHAIN_LEN-1];
    end else if (state_q == S_SHIFT) begin
      res_data <= capture;
      load_sr  <= load_sr << 1;
      k_q      <= k_q + 1'b1;
      if (last_shift) begin
        se        <= 1'b0;
        si        <= 1'b0;
        res_valid <= 1'b1;
        res_errs  <= errs_d;
        res_fail  <= (errs_d != '0);
        if (errs_d != '0) begin
          if (fail_cnt != '1) fail_cnt <= fail_cnt + 1'b1;
        end else begin
          if (pass_cnt != '1) pass_cnt <= pass_cnt + 1'b1;
        end
      end else begin
        si <= load_sr[CHAIN_LEN-1];
      end
    end else if (state_q == S_RESULT && res_ready) begin
      res_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_scan_chain_driver.sv
// Bench: scan_chain_driver wired to an 8-flop scan chain, graded against a transaction-level model.
// Expectations follow SCAN_XMASK_EN when it is defined for the build.
module tb_scan_chain_driver;

  logic       sclk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pat_valid = 1'b0;
  logic       pat_ready;
  logic [7:0] pat_load = 8'h00;
  logic [7:0] pat_exp = 8'h00;
  logic [7:0] pat_mask = 8'hFF;
  logic       se, si, so;
  logic       res_valid;
  logic       res_ready = 1'b0;
  logic [7:0] res_data;
  logic       res_fail;
  logic [3:0] res_errs;
  logic [15:0] pass_cnt, fail_cnt;

  int n_checks = 0;
  int n_fail = 0;
  int se_cycles = 0;

  // Scan chain environment, with an optional stuck-at-1 on its output.
  logic [7:0] chain = 8'h00;
  logic       stuck = 1'b0;

  always @(posedge sclk) if (se === 1'b1) chain <= {chain[6:0], si};
  assign so = stuck ? 1'b1 : chain[7];

  always #5 sclk = ~sclk;

  scan_chain_driver #(.CHAIN_LEN(8), .TALLY_W(16)) dut (
    .sclk(sclk), .rst_n(rst_n),
    .pat_valid(pat_valid), .pat_ready(pat_ready),
    .pat_load(pat_load), .pat_exp(pat_exp), .pat_mask(pat_mask),
    .se(se), .si(si), .so(so),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_fail(res_fail), .res_errs(res_errs),
    .pass_cnt(pass_cnt), .fail_cnt(fail_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: m_left counts remaining shift cycles, m_res marks a pending result.
  int         m_left = 0;
  bit         m_res = 1'b0;
  logic [7:0] m_chain = 8'h00;
  logic [7:0] m_load = 8'h00;
  logic [7:0] m_data = 8'h00;
  int         m_errs = 0;
  int         m_pass = 0;
  int         m_fail = 0;

  function automatic logic [7:0] eff_mask(input logic [7:0] m);
`ifdef SCAN_XMASK_EN
    return m;
`else
    return 8'hFF;
`endif
  endfunction

  always @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      m_left = 0;
      m_res  = 1'b0;
      m_pass = 0;
      m_fail = 0;
    end else if (m_res) begin
      if (res_ready) m_res = 1'b0;
    end else if (m_left > 0) begin
      m_chain = {m_chain[6:0], m_load[m_left-1]};
      m_left--;
      if (m_left == 0) begin
        m_res = 1'b1;
        if (m_errs != 0) begin
          if (m_fail != 16'hFFFF) m_fail++;
        end else begin
          if (m_pass != 16'hFFFF) m_pass++;
        end
      end
    end else if (pat_valid) begin
      m_load = pat_load;
      m_data = stuck ? 8'hFF : m_chain;
      m_errs = $countones((m_data ^ pat_exp) & eff_mask(pat_mask));
      m_left = 8;
    end
  end

  always @(negedge sclk) begin
    if (se === 1'b1) se_cycles++;
    check("pat_ready", pat_ready, (m_left == 0 && !m_res));
    check("se", se, (m_left > 0));
    check("si", si, (m_left > 0) ? m_load[m_left-1] : 1'b0);
    check("res_valid", res_valid, m_res);
    if (m_res) begin
      check("res_data", res_data, m_data);
      check("res_errs", res_errs, m_errs);
      check("res_fail", res_fail, (m_errs != 0));
    end
    check("pass_cnt", pass_cnt, m_pass);
    check("fail_cnt", fail_cnt, m_fail);
  end

  task automatic send(input logic [7:0] ld, input logic [7:0] ex, input logic [7:0] mk);
    bit ok;
    ok = 1'b0;
    pat_load = ld; pat_exp = ex; pat_mask = mk; pat_valid = 1'b1;
    for (int i = 0; i < 100 && !ok; i++) begin
      if (pat_ready === 1'b1) ok = 1'b1;
      @(negedge sclk);
    end
    pat_valid = 1'b0;
    check("accept_in_time", ok, 1);
  endtask

  task automatic wait_result();
    for (int i = 0; i < 100 && res_valid !== 1'b1; i++) @(negedge sclk);
    check("result_in_time", res_valid, 1);
  endtask

  task automatic consume();
    res_ready = 1'b1;
    @(negedge sclk);
    res_ready = 1'b0;
  endtask

  initial begin
    int se0;
    repeat (3) @(negedge sclk);
    check("rst_se", se, 0);
    check("rst_si", si, 0);
    check("rst_pat_ready", pat_ready, 1);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_data", res_data, 8'h00);
    check("rst_res_errs", res_errs, 0);
    check("rst_res_fail", res_fail, 0);
    check("rst_pass_cnt", pass_cnt, 0);
    check("rst_fail_cnt", fail_cnt, 0);
    #2 rst_n = 1'b1;
    @(negedge sclk);

    // Chain starts cleared; A5 goes in, 00 comes out.
    se0 = se_cycles;
    send(8'hA5, 8'h00, 8'hFF);
    wait_result();
    check("t1_se_cycles", se_cycles - se0, 8);
    check("t1_res_data", res_data, 8'h00);
    check("t1_res_fail", res_fail, 0);
    check("t1_pass_cnt", pass_cnt, 1);
    consume();

    send(8'h3C, 8'hA5, 8'hFF);
    wait_result();
    check("t2_res_data", res_data, 8'hA5);
    check("t2_res_errs", res_errs, 0);
    consume();

    send(8'h00, 8'hFF, 8'hFF);
    wait_result();
    check("t2b_res_data", res_data, 8'h3C);
    check("t2b_res_errs", res_errs, 4);
    check("t2b_res_fail", res_fail, 1);
    check("t2b_fail_cnt", fail_cnt, 1);

    // Result held under backpressure while a new pattern is offered.
    pat_load = 8'h5A; pat_exp = 8'h00; pat_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge sclk);
      check("t3_pat_ready", pat_ready, 0);
      check("t3_se", se, 0);
      check("t3_res_data", res_data, 8'h3C);
      check("t3_res_errs", res_errs, 4);
    end
    pat_valid = 1'b0;
    consume();

    // Reset in the middle of a shift, at k=3.
    send(8'hF0, 8'h00, 8'hFF);
    repeat (3) @(negedge sclk);
    #2 rst_n = 1'b0;
    #1;
    check("t4_se", se, 0);
    check("t4_res_valid", res_valid, 0);
    check("t4_pass_cnt", pass_cnt, 0);
    check("t4_fail_cnt", fail_cnt, 0);
    @(negedge sclk);
    #2 rst_n = 1'b1;
    @(negedge sclk);
    // Three shifts of F0's top bits landed on top of 00.
    send(8'h81, 8'h07, 8'hFF);
    wait_result();
    check("t4_res_data", res_data, 8'h07);
    check("t4_pass_after", pass_cnt, 1);
    consume();

    send(8'h0F, 8'h81, 8'hFF);
    wait_result();
    consume();
    send(8'h00, 8'hFF, 8'h0F);
    wait_result();
    check("t5_res_data", res_data, 8'h0F);
`ifdef SCAN_XMASK_EN
    check("t5_res_errs", res_errs, 0);
    check("t5_res_fail", res_fail, 0);
`else
    check("t5_res_errs", res_errs, 4);
    check("t5_res_fail", res_fail, 1);
`endif
    consume();

    stuck = 1'b1;
    send(8'h00, 8'h00, 8'hFF);
    wait_result();
    consume();
    send(8'h00, 8'h00, 8'hFF);
    wait_result();
    check("t6_res_data", res_data, 8'hFF);
    check("t6_res_errs", res_errs, 8);
    check("t6_res_fail", res_fail, 1);
    consume();
    stuck = 1'b0;

    repeat (2) @(negedge sclk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
